// File: rtl/sram_23k640_pkg.sv
// Shared definitions for the 23K640 serial SRAM device model.
// Holds the SPI opcodes, the status-register mode encodings, the responder
// FSM state type and a helper that builds a status value from a WRSR byte.
package sram_23k640_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WRSR  = 8'h01;

  // status[7:6]; 2'b11 is reserved and behaves as byte mode
  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_SEQ  = 2'b01;
  localparam logic [1:0] MODE_PAGE = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StRdData,
    StWrData,
    StRdsr,
    StWrsr,
    StIgnore
  } state_e;

  // Only the mode bits and bit 0 are stored; bits 5:1 always read as zero.
  function automatic logic [7:0] status_from_byte(logic [7:0] b);
    return {b[7:6], 5'b0_0000, b[0]};
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Brings the asynchronous SPI pins into the i_clk domain.
// Ports:
//   i_clk, i_rst  system clock, asynchronous active-high reset
//   sck_i/cs_i/si_i  raw SPI pins (CS active low)
//   sck_rise_o/sck_fall_o  one-cycle pulses on synchronized SCK edges
//   cs_n_o  synchronized chip select (active low), si_o  synchronized MOSI
module spi_slave_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic sck_i,
  input  logic cs_i,
  input  logic si_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic cs_n_o,
  output logic si_o
);

  logic [1:0] sck_q;
  logic [1:0] cs_q;
  logic [1:0] si_q;
  logic       sck_dly_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sck_q     <= 2'b00;
      cs_q      <= 2'b11;  // deselected out of reset
      si_q      <= 2'b00;
      sck_dly_q <= 1'b0;
    end else begin
      sck_q     <= {sck_q[0], sck_i};
      cs_q      <= {cs_q[0], cs_i};
      si_q      <= {si_q[0], si_i};
      sck_dly_q <= sck_q[1];
    end
  end

  // Edge pulses come straight off flops so the FSM reacts on the third
  // i_clk edge after a pin transition. SI goes through the same depth, so it
  // is aligned with the rise pulse.
  assign sck_rise_o = sck_q[1] & ~sck_dly_q;
  assign sck_fall_o = ~sck_q[1] & sck_dly_q;
  assign cs_n_o     = cs_q[1];
  assign si_o       = si_q[1];

endmodule

// File: rtl/sram_23k640_slave.sv
// Oversampled SPI mode-0 responder emulating a 23K640 serial SRAM.
// Supports READ, WRITE, RDSR and WRSR with byte, page and sequential modes.
// Ports:
//   i_clk, i_rst  system clock, asynchronous active-high reset
//   i_sck, i_cs, i_si  SPI from the master (CS active low), async to i_clk
//   o_so          MISO, updated after synchronized SCK falling edges
//   i_bd_addr     backdoor read address
//   o_bd_data     backdoor read data, combinational from the array
//   o_status      status register
//   o_busy        synchronized chip-select asserted
module sram_23k640_slave
  import sram_23k640_pkg::*;
#(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned PAGE_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sck,
  input  logic              i_cs,
  input  logic              i_si,
  output logic              o_so,
  input  logic [ADDR_W-1:0] i_bd_addr,
  output logic [7:0]        o_bd_data,
  output logic [7:0]        o_status,
  output logic              o_busy
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic sck_rise;
  logic sck_fall;
  logic cs_n;
  logic si;

  spi_slave_sync u_sync (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .sck_i      (i_sck),
    .cs_i       (i_cs),
    .si_i       (i_si),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .cs_n_o     (cs_n),
    .si_o       (si)
  );

  state_e            state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [14:0]       in_sh_q, in_sh_d;
  logic [7:0]        out_sh_q, out_sh_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        status_q, status_d;
  logic              so_q, so_d;
  logic              first_q, first_d;  // no data byte transferred yet
  logic              is_wr_q, is_wr_d;

  logic [7:0]        mem [Depth];
  logic              mem_we;
  logic [7:0]        rd_data;

  logic [15:0]       in_word;
  logic [7:0]        in_byte;
  logic [1:0]        mode;
  logic              adv_ok;
  logic [PAGE_W-1:0] page_off;
  logic [ADDR_W-1:0] addr_next;
  logic              unused_addr_hi;

  assign in_word        = {in_sh_q, si};
  assign in_byte        = in_word[7:0];
  assign unused_addr_hi = ^in_word[15:ADDR_W];
  assign rd_data        = mem[addr_q];

  assign mode     = status_q[7:6];
  assign adv_ok   = (mode == MODE_SEQ) || (mode == MODE_PAGE);
  assign page_off = addr_q[PAGE_W-1:0] + 1'b1;

  always_comb begin
    addr_next = addr_q;
    if (mode == MODE_SEQ) begin
      addr_next = addr_q + 1'b1;
    end else if (mode == MODE_PAGE) begin
      addr_next = {addr_q[ADDR_W-1:PAGE_W], page_off};
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    in_sh_d   = in_sh_q;
    out_sh_d  = out_sh_q;
    addr_d    = addr_q;
    status_d  = status_q;
    so_d      = so_q;
    first_d   = first_q;
    is_wr_d   = is_wr_q;
    mem_we    = 1'b0;

    if (cs_n) begin
      // Deselect wins over any SCK edge in the same cycle; partial bytes die here.
      state_d   = StIdle;
      bit_cnt_d = 5'd0;
      so_d      = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d   = StCmd;
          bit_cnt_d = 5'd0;
          so_d      = 1'b0;
        end

        StCmd: begin
          if (sck_rise) begin
            in_sh_d   = in_word[14:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
              case (in_byte)
                OP_READ: begin
                  state_d = StAddr;
                  is_wr_d = 1'b0;
                end
                OP_WRITE: begin
                  state_d = StAddr;
                  is_wr_d = 1'b1;
                end
                OP_RDSR: state_d = StRdsr;
                OP_WRSR: state_d = StWrsr;
                default: state_d = StIgnore;
              endcase
            end
          end
        end

        StAddr: begin
          if (sck_rise) begin
            in_sh_d   = in_word[14:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd15) begin
              bit_cnt_d = 5'd0;
              addr_d    = in_word[ADDR_W-1:0];
              first_d   = 1'b1;
              state_d   = is_wr_q ? StWrData : StRdData;
            end
          end
        end

        StRdData: begin
          if (sck_fall) begin
            if (bit_cnt_q == 5'd0) begin
              // Byte boundary: load the next byte unless byte mode has used its one byte.
              if (!first_q && !adv_ok) begin
                state_d = StIgnore;
                so_d    = 1'b0;
              end else begin
                so_d      = rd_data[7];
                out_sh_d  = {rd_data[6:0], 1'b0};
                first_d   = 1'b0;
                bit_cnt_d = 5'd1;
              end
            end else begin
              so_d     = out_sh_q[7];
              out_sh_d = {out_sh_q[6:0], 1'b0};
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_d = 5'd0;
                addr_d    = addr_next;
              end else begin
                bit_cnt_d = bit_cnt_q + 5'd1;
              end
            end
          end
        end

        StWrData: begin
          if (sck_rise) begin
            in_sh_d   = in_word[14:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              mem_we    = 1'b1;
              bit_cnt_d = 5'd0;
              addr_d    = addr_next;
              if (!adv_ok) begin
                state_d = StIgnore;
              end
            end
          end
        end

        StRdsr: begin
          if (sck_fall) begin
            so_d      = status_q[3'd7 - bit_cnt_q[2:0]];
            bit_cnt_d = {2'b00, bit_cnt_q[2:0] + 3'd1};
          end
        end

        StWrsr: begin
          if (sck_rise) begin
            in_sh_d   = in_word[14:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              status_d = status_from_byte(in_byte);
              state_d  = StIgnore;
            end
          end
        end

        StIgnore: begin
          so_d = 1'b0;
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= 5'd0;
      in_sh_q   <= '0;
      out_sh_q  <= '0;
      addr_q    <= '0;
      status_q  <= 8'h00;
      so_q      <= 1'b0;
      first_q   <= 1'b0;
      is_wr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      in_sh_q   <= in_sh_d;
      out_sh_q  <= out_sh_d;
      addr_q    <= addr_d;
      status_q  <= status_d;
      so_q      <= so_d;
      first_q   <= first_d;
      is_wr_q   <= is_wr_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[addr_q] <= in_byte;
    end
  end

  assign o_bd_data = mem[i_bd_addr];
  assign o_so      = so_q;
  assign o_status  = status_q;
  assign o_busy    = ~cs_n;

endmodule
